id_ex_pipeline_reg: RTL
=======================

# id_ex_pipeline_reg

ID/EX pipeline register with integrated load-use hazard detection and multi-cycle divide hold. It sits directly upstream of the EX-stage forwarding unit and supplies its `Instruction`, `RegisterDestination` and `EX_RegisterWrite` inputs. It captures decode-stage operands and control each cycle. It inserts a bubble on a load-use dependency, holds a divide in EX for a fixed number of cycles, and squashes on a branch/jump flush.

## Interface
Parameters:
- DATA_W, 32, datapath width
- DIV_CYCLES, 4, total cycles a div/divu occupies EX (minimum 1)

Ports:
- Clk  in  1  pipeline clock, all state updates on rising edge
- Rst_n  in  1  synchronous, active-low reset
- ID_Instruction  in  32  decoded instruction word
- ID_ReadData1 / ID_ReadData2  in  DATA_W  register file rs/rt data
- ID_SignExtImm  in  DATA_W  sign-extended immediate
- ID_RegisterDestination  in  5  resolved destination (rd/rt/31)
- ID_RegisterWrite, ID_MemRead, ID_MemWrite  in  1  decode control
- ID_Valid  in  1  IF/ID slot holds a real instruction
- Flush  in  1  taken branch/jump; squash the ID slot
- EX_Instruction  out  32  to forwarding unit `Instruction`
- EX_ReadData1 / EX_ReadData2 / EX_SignExtImm  out  DATA_W  registered operands
- RegisterDestination  out  32  registered destination, zero-extended from 5 bits
- EX_RegisterWrite, EX_MemRead, EX_MemWrite, EX_Valid  out  1  registered control
- StallIF  out  1  hold PC and IF/ID this cycle
- DivBusy  out  1  EX holds a divide; EX/MEM must capture a bubble

Clock is `Clk`. Reset is `Rst_n`: one clock, reset synchronous and active-low.

## Operation
- Bubble = all registered outputs zero (Instruction 0 = sll $0 nop, all control 0, Valid 0).
- Load-use hazard (combinational, state RUN only) asserts when all of the following hold:
  - EX_Valid && EX_MemRead && RegisterDestination[4:0] != 0
  - ID_Valid
  - the destination equals ID rs (bits 25:21), or equals ID rt (bits 20:16) when the ID opcode reads rt: 000000, 011100, 101011, 101001, 101000, 000100, 000101
- States:
  - RUN: normal operation.
  - DIV_BUSY: a 3-bit-wide-enough down-counter `cnt` is nonzero.
- Next-state priority at each edge (highest first):
  1. !Rst_n -> bubble, RUN, cnt=0
  2. Flush -> bubble, RUN, cnt=0 (aborts DIV_BUSY)
  3. DIV_BUSY -> hold all registers; cnt--; go to RUN when cnt reaches 0
  4. load-use hazard -> capture bubble
  5. otherwise capture ID inputs; if the captured instruction is opcode 000000 with funct 011010/011011, ID_Valid=1 and DIV_CYCLES>1, then cnt=DIV_CYCLES-1 and enter DIV_BUSY
- StallIF = load-use hazard || state==DIV_BUSY, and is forced 0 when Flush=1.
- DivBusy = (state==DIV_BUSY).

## Timing
- Capture latency: 1 cycle from ID inputs to EX outputs.
- All outputs reset to 0; state RUN.
- Load-use costs exactly one bubble. On the following cycle the load has moved to MEM, the hazard deasserts, and the held ID instruction is captured.
- A divide stays in EX for DIV_CYCLES cycles. StallIF=DivBusy=1 for DIV_CYCLES-1 cycles, starting the cycle after capture.
- Back-to-back divides: the second is held in IF/ID by StallIF and captured the cycle DIV_BUSY exits.
- Rst_n low mid-DIV_BUSY or mid-stall: the next edge yields a bubble and RUN.

## Configuration
- ID_EX_PERF_CNT_EN defined: adds outputs StallCount and BubbleCount (32 bits each, reset 0, wrap modulo 2^32).
  - StallCount increments every cycle StallIF=1.
  - BubbleCount increments on every edge that captures a bubble due to load-use or Flush.
- ID_EX_PERF_CNT_EN undefined: the ports and logic are absent; behaviour is otherwise identical.

## Structure
- Shared package holds:
  - opcode constants: OP_RTYPE 000000, OP_SPECIAL2 011100, OP_LW 100011, OP_LH 100001, OP_LB 100000, OP_SW 101011, OP_SH 101001, OP_SB 101000, OP_BEQ 000100, OP_BNE 000101
  - funct constants: FN_DIV 011010, FN_DIVU 011011
  - state encoding RUN/DIV_BUSY
- One sub-module, load_use_detect: purely combinational rs/rt compare producing the hazard bit.

## Test plan
- Reset: Rst_n=0 for 2 cycles with nonzero ID inputs -> all outputs 0, StallIF=0.
- lw $8 then add $9,$8,$10 -> add held; EX shows bubble for 1 cycle (StallIF=1), add in EX the next cycle; lw to $0 -> no stall.
- div $4,$5 with DIV_CYCLES=4 -> EX_Instruction holds div for 4 cycles; StallIF=DivBusy=1 for 3 cycles, then the next instruction is captured.
- Flush=1 in the second DIV_BUSY cycle -> next edge bubble, DivBusy=0, StallIF=0 during the Flush cycle.
- Simultaneous load-use and Flush -> bubble captured, StallIF=0.
- With ID_EX_PERF_CNT_EN: one load-use plus one div (DIV_CYCLES=4) -> StallCount=4, BubbleCount=1.

Source files
------------

// File: rtl/id_ex_pipeline_reg_pkg.sv
// Shared definitions for the ID/EX pipeline register slice.
//   - opcode / funct constants used by hazard and divide detection
//   - RUN / DIV_BUSY state encoding
//   - registered control bundle type
//   - decode helpers (rt-reading opcodes, divide detection)
package id_ex_pipeline_reg_pkg;

  localparam logic [5:0] OP_RTYPE    = 6'b000000;
  localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
  localparam logic [5:0] OP_LW       = 6'b100011;
  localparam logic [5:0] OP_LH       = 6'b100001;
  localparam logic [5:0] OP_LB       = 6'b100000;
  localparam logic [5:0] OP_SW       = 6'b101011;
  localparam logic [5:0] OP_SH       = 6'b101001;
  localparam logic [5:0] OP_SB       = 6'b101000;
  localparam logic [5:0] OP_BEQ      = 6'b000100;
  localparam logic [5:0] OP_BNE      = 6'b000101;

  localparam logic [5:0] FN_DIV      = 6'b011010;
  localparam logic [5:0] FN_DIVU     = 6'b011011;

  typedef enum logic {
    RUN      = 1'b0,
    DIV_BUSY = 1'b1
  } state_e;

  typedef struct packed {
    logic rw;   // register write
    logic mr;   // memory read
    logic mw;   // memory write
    logic vld;  // slot holds a real instruction
  } ctrl_t;

  // Opcodes whose rt field is a source operand (stores/branches/R-type).
  function automatic logic reads_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_SPECIAL2) || (op == OP_SW) ||
           (op == OP_SH) || (op == OP_SB) || (op == OP_BEQ) || (op == OP_BNE);
  endfunction

  function automatic logic is_div(input logic [5:0] op, input logic [5:0] funct);
    return (op == OP_RTYPE) && ((funct == FN_DIV) || (funct == FN_DIVU));
  endfunction

endpackage

// File: rtl/id_ex_pipeline_reg_load_use_detect.sv
// load_use_detect: combinational load-use hazard compare.
// Fires when the EX slot holds a valid load to a nonzero register that the
// ID instruction reads through rs, or through rt for opcodes that source rt.
//   ex_valid_i, ex_memread_i, ex_dst_i : EX slot load info
//   id_valid_i, id_op_i, id_rs_i, id_rt_i : ID slot source fields
//   hazard_o : dependency present (caller gates with pipeline state)
module load_use_detect
  import id_ex_pipeline_reg_pkg::*;
(
  input  logic       ex_valid_i,
  input  logic       ex_memread_i,
  input  logic [4:0] ex_dst_i,
  input  logic       id_valid_i,
  input  logic [5:0] id_op_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  output logic       hazard_o
);

  logic ex_load;
  logic rs_hit;
  logic rt_hit;

  assign ex_load  = ex_valid_i && ex_memread_i && (ex_dst_i != 5'd0);
  assign rs_hit   = (ex_dst_i == id_rs_i);
  assign rt_hit   = reads_rt(id_op_i) && (ex_dst_i == id_rt_i);
  assign hazard_o = ex_load && id_valid_i && (rs_hit || rt_hit);

endmodule

// File: rtl/id_ex_pipeline_reg.sv
// id_ex_pipeline_reg: ID/EX pipeline register with load-use bubble
// insertion, multi-cycle divide hold and branch/jump flush.
//   Inputs : Clk, Rst_n (sync, active low), ID_* decode operands/control,
//            Flush (squash ID slot)
//   Outputs: EX_* registered operands/control, RegisterDestination
//            (zero-extended), StallIF (hold PC and IF/ID), DivBusy
// Optional: ID_EX_PERF_CNT_EN adds StallCount / BubbleCount outputs.
module id_ex_pipeline_reg
  import id_ex_pipeline_reg_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DIV_CYCLES = 4
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [31:0]       ID_Instruction,
  input  logic [DATA_W-1:0] ID_ReadData1,
  input  logic [DATA_W-1:0] ID_ReadData2,
  input  logic [DATA_W-1:0] ID_SignExtImm,
  input  logic [4:0]        ID_RegisterDestination,
  input  logic              ID_RegisterWrite,
  input  logic              ID_MemRead,
  input  logic              ID_MemWrite,
  input  logic              ID_Valid,
  input  logic              Flush,
  output logic [31:0]       EX_Instruction,
  output logic [DATA_W-1:0] EX_ReadData1,
  output logic [DATA_W-1:0] EX_ReadData2,
  output logic [DATA_W-1:0] EX_SignExtImm,
  output logic [31:0]       RegisterDestination,
  output logic              EX_RegisterWrite,
  output logic              EX_MemRead,
  output logic              EX_MemWrite,
  output logic              EX_Valid,
  output logic              StallIF,
`ifdef ID_EX_PERF_CNT_EN
  output logic [31:0]       StallCount,
  output logic [31:0]       BubbleCount,
`endif
  output logic              DivBusy
);

  // Counter holds DIV_CYCLES-1 at most.
  localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(DIV_CYCLES - 1);

  logic [31:0]       instr_q, instr_d;
  logic [DATA_W-1:0] rd1_q, rd1_d;
  logic [DATA_W-1:0] rd2_q, rd2_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [4:0]        dst_q, dst_d;
  ctrl_t             ctrl_q, ctrl_d;
  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic hazard;
  logic haz_run;

  load_use_detect u_lud (
    .ex_valid_i   (ctrl_q.vld),
    .ex_memread_i (ctrl_q.mr),
    .ex_dst_i     (dst_q),
    .id_valid_i   (ID_Valid),
    .id_op_i      (ID_Instruction[31:26]),
    .id_rs_i      (ID_Instruction[25:21]),
    .id_rt_i      (ID_Instruction[20:16]),
    .hazard_o     (hazard)
  );

  // The load-use check is meaningless while a divide owns EX.
  assign haz_run = hazard && (state_q == RUN);

  always_comb begin
    instr_d = instr_q;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    imm_d   = imm_q;
    dst_d   = dst_q;
    ctrl_d  = ctrl_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (Flush) begin
      instr_d = '0; rd1_d = '0; rd2_d = '0; imm_d = '0; dst_d = '0; ctrl_d = '0;
      state_d = RUN;
      cnt_d   = '0;
    end else if (state_q == DIV_BUSY) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) state_d = RUN;
    end else if (haz_run) begin
      instr_d = '0; rd1_d = '0; rd2_d = '0; imm_d = '0; dst_d = '0; ctrl_d = '0;
    end else begin
      instr_d = ID_Instruction;
      rd1_d   = ID_ReadData1;
      rd2_d   = ID_ReadData2;
      imm_d   = ID_SignExtImm;
      dst_d   = ID_RegisterDestination;
      ctrl_d  = '{rw: ID_RegisterWrite, mr: ID_MemRead, mw: ID_MemWrite, vld: ID_Valid};
      if ((DIV_CYCLES > 1) && ID_Valid &&
          is_div(ID_Instruction[31:26], ID_Instruction[5:0])) begin
        state_d = DIV_BUSY;
        cnt_d   = CNT_LOAD;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      instr_q <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      dst_q   <= '0;
      ctrl_q  <= '0;
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      instr_q <= instr_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      imm_q   <= imm_d;
      dst_q   <= dst_d;
      ctrl_q  <= ctrl_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign EX_Instruction      = instr_q;
  assign EX_ReadData1        = rd1_q;
  assign EX_ReadData2        = rd2_q;
  assign EX_SignExtImm       = imm_q;
  assign RegisterDestination = {27'd0, dst_q};
  assign EX_RegisterWrite    = ctrl_q.rw;
  assign EX_MemRead          = ctrl_q.mr;
  assign EX_MemWrite         = ctrl_q.mw;
  assign EX_Valid            = ctrl_q.vld;
  assign DivBusy             = (state_q == DIV_BUSY);
  // A taken branch discards the ID slot, so there is nothing to hold.
  assign StallIF             = (haz_run || DivBusy) && !Flush;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] bub_cnt_q;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      stall_cnt_q <= '0;
      bub_cnt_q   <= '0;
    end else begin
      if (StallIF)           stall_cnt_q <= stall_cnt_q + 32'd1;
      if (Flush || haz_run)  bub_cnt_q   <= bub_cnt_q + 32'd1;
    end
  end

  assign StallCount  = stall_cnt_q;
  assign BubbleCount = bub_cnt_q;
`endif

endmodule
